mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Clock and reset SHALL be one clock and a synchronous, active-low reset, named as in the codebase:
  - clock  input  1  sole clock; all state updates on its rising edge.
  - rst  input  1  synchronous active-low reset; low at a rising edge resets all state.
REQ-002 Parameters (name, default, meaning) SHALL be:
  - MEM_BYTES, 524288, backing memory size in bytes.
  - STARVE_MAX, 4, consecutive data grants allowed while fetch waits.
REQ-003 Fetch port signals (name, direction, width, meaning) SHALL be:
  - if_req_valid  in  1  fetch request.
  - if_req_ready  out  1  fetch accepted.
  - if_addr  in  64  fetch byte address.
  - if_rsp_valid  out  1  fetch response valid.
  - if_rsp_ready  in  1  fetch response taken.
  - if_rsp_data  out  32  instruction word.
REQ-004 Data port signals (name, direction, width, meaning) SHALL be:
  - d_req_valid  in  1  data request.
  - d_req_ready  out  1  data request accepted.
  - d_we  in  1  1 = store, 0 = load.
  - d_addr  in  64  data byte address.
  - d_wdata  in  64  store data.
  - d_rsp_valid  out  1  data response valid.
  - d_rsp_ready  in  1  data response taken.
  - d_rsp_data  out  64  load data; 0 for stores.
REQ-005 Shared signals (name, direction, width, meaning) SHALL be:
  - rsp_err  out  1  qualifies whichever rsp_valid is high; 1 = address fault.
  - mem_en  out  1  memory access strobe.
  - mem_we  out  1  memory write.
  - mem_size  out  1  0 = 4 bytes, 1 = 8 bytes.
  - mem_addr  out  64  memory byte address.
  - mem_wdata  out  64  memory write data.
  - mem_rdata  in  64  read data, valid the cycle after a read strobe; 4-byte reads use bits [31:0].

Function
REQ-006 FSM states SHALL be IDLE, ISSUE, CAPTURE and RESP; at most one transaction is outstanding.
REQ-007 A handshake SHALL complete when a port's req_valid and req_ready are both 1 at a rising edge.
  - req_ready SHALL be high only in IDLE, and only for the granted port.
  - Grant is combinational from the valid inputs and the starvation counter.
REQ-008 Grant rules:
  - Only one port valid: that port is granted.
  - Both valid: data is granted, unless the starvation counter equals STARVE_MAX, in which case fetch is granted.
REQ-009 Starvation counter (3 bits, saturating at STARVE_MAX):
  - Increments on each data grant while if_req_valid = 1.
  - Clears on a fetch grant, or in any IDLE cycle with if_req_valid = 0.
REQ-010 On handshake the block SHALL register port, address, size, d_we and d_wdata, then go IDLE -> ISSUE.
  - If addr + size_bytes > MEM_BYTES (64-bit unsigned compare, carry included), go IDLE -> RESP instead.
  - In that case rsp_err = 1, response data = 0, and no memory strobe is issued.
REQ-011 ISSUE SHALL last exactly one cycle:
  - mem_en = 1; mem_we = latched d_we.
  - mem_addr, mem_size and mem_wdata driven from the registers.
  - Next state: CAPTURE.
REQ-012 CAPTURE SHALL register mem_rdata (reads: low 32 bits for fetch, all 64 bits for data; writes capture 0), then go to RESP.
REQ-013 RESP SHALL hold the granted port's rsp_valid, rsp_data and rsp_err stable until that port's rsp_ready = 1, then go to IDLE.
  - Minimum latency from accept edge to rsp_valid is 3 cycles; peak throughput is one transaction per 4 cycles.
REQ-014 Outside ISSUE, mem_en and mem_we SHALL be 0.
  - The non-granted port's rsp_valid SHALL always be 0.
  - rsp_err SHALL be 0 whenever neither rsp_valid is high.
REQ-015 Requests arriving outside IDLE SHALL be neither accepted nor dropped; the requester holds valid.

Reset
REQ-016 When rst = 0 at an edge:
  - State -> IDLE; starvation counter -> 0; all request and response registers -> 0.
  - All outputs 0 the following cycle.
REQ-017 mem_en and mem_we SHALL be gated by rst, so no store commits in any cycle where rst = 0, including a reset that arrives mid-ISSUE.
  - An in-flight transaction is discarded without a response.

Structure
REQ-018 Package tinker_mem_pkg SHALL hold:
  - The state enum.
  - MEM_BYTES and STARVE_MAX defaults.
  - The mem_size encoding constants.
REQ-019 The grant selection and starvation counter SHALL form one sub-module, arb_priority; the FSM and datapath registers remain in mem_port_arbiter.

Verification
REQ-020 Directed scenarios the bench SHALL cover:
  - Fetch only: if_addr = 0x2000, memory holds 0x12345678 -> mem_en in cycle +1, if_rsp_valid with data 0x12345678 in cycle +3, rsp_err = 0.
  - Store then load: d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEFCAFEF00D, then a load from 0x100 -> d_rsp_data = 0xDEADBEEFCAFEF00D.
  - Both ports held valid continuously, with responses taken immediately -> grant order D, D, D, D, IF, D, D, D, D, IF.
  - Load at d_addr = 0x7FFF9 (MEM_BYTES = 0x80000) -> no mem_en pulse, d_rsp_valid with rsp_err = 1 and data 0.
  - Fetch at if_addr = 0xFFFFFFFFFFFFFFFE -> rsp_err = 1 (wrap caught).
  - d_rsp_ready held 0 for 10 cycles -> response stable throughout, no new request accepted.
  - rst = 0 during ISSUE of a store to 0x200 -> mem_we = 0 that cycle, memory unchanged, all outputs 0 after reset.

Source files
------------

// File: rtl/tinker_mem_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package tinker_mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam longint unsigned MEM_BYTES_DEFAULT  = 64'd524288;
   localparam int unsigned     STARVE_MAX_DEFAULT = 4;

   localparam logic SIZE_4B = 1'b0;
   localparam logic SIZE_8B = 1'b1;

   function automatic logic [3:0] size_bytes(input logic size);
      return (size == SIZE_8B) ? 4'd8 : 4'd4;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_priority.sv
// Fetch/data grant selection with a saturating counter that bounds how long
// fetch can be held off while data keeps winning.
module arb_priority
   import tinker_mem_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic clock,
   input  logic rst,
   input  logic in_idle,
   input  logic if_valid,
   input  logic d_valid,
   output logic grant_if,
   output logic grant_d
);

   localparam logic [2:0] CNT_MAX = 3'(STARVE_MAX);

   logic [2:0] starve_cnt;

   always_comb begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
      if (if_valid && d_valid) begin
         if (starve_cnt == CNT_MAX) grant_if = 1'b1;
         else                       grant_d  = 1'b1;
      end else begin
         grant_if = if_valid;
         grant_d  = d_valid;
      end
   end

   // Grants in IDLE are always handshakes, so counting is gated on IDLE only.
   always_ff @(posedge clock) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (in_idle) begin
         if (grant_if || !if_valid)
            starve_cnt <= '0;
         else if (grant_d && (starve_cnt != CNT_MAX))
            starve_cnt <= starve_cnt + 3'd1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data,
// with address range checking and held responses.
module mem_port_arbiter
   import tinker_mem_pkg::*;
#(
   parameter longint unsigned MEM_BYTES  = MEM_BYTES_DEFAULT,
   parameter int unsigned     STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [63:0] if_addr,
   output logic        if_rsp_valid,
   input  logic        if_rsp_ready,
   output logic [31:0] if_rsp_data,
   input  logic        d_req_valid,
   output logic        d_req_ready,
   input  logic        d_we,
   input  logic [63:0] d_addr,
   input  logic [63:0] d_wdata,
   output logic        d_rsp_valid,
   input  logic        d_rsp_ready,
   output logic [63:0] d_rsp_data,
   output logic        rsp_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic        mem_size,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata
);

   state_t      state, state_next;
   logic        in_idle, grant_if, grant_d, hs;
   logic [63:0] sel_addr;
   logic        sel_size, sel_fault;
   logic [64:0] end_addr;
   logic        lat_port_d, lat_we, lat_size, lat_err;
   logic [63:0] lat_addr, lat_wdata, rsp_data;
   logic        rsp_taken;

   assign in_idle = (state == IDLE);

   arb_priority #(.STARVE_MAX(STARVE_MAX)) u_arb (
      .clock    (clock),
      .rst      (rst),
      .in_idle  (in_idle),
      .if_valid (if_req_valid),
      .d_valid  (d_req_valid),
      .grant_if (grant_if),
      .grant_d  (grant_d)
   );

   assign if_req_ready = rst & in_idle & grant_if;
   assign d_req_ready  = rst & in_idle & grant_d;
   assign hs = (if_req_valid & if_req_ready) | (d_req_valid & d_req_ready);

   // One extra bit keeps the carry so addresses that wrap past 2^64 fault too.
   assign sel_addr  = grant_d ? d_addr : if_addr;
   assign sel_size  = grant_d ? SIZE_8B : SIZE_4B;
   assign end_addr  = {1'b0, sel_addr} + 65'(size_bytes(sel_size));
   assign sel_fault = end_addr > 65'(MEM_BYTES);

   assign rsp_taken = lat_port_d ? d_rsp_ready : if_rsp_ready;

   always_ff @(posedge clock) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next   = state;
      if_rsp_valid = 1'b0;
      if_rsp_data  = '0;
      d_rsp_valid  = 1'b0;
      d_rsp_data   = '0;
      rsp_err      = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_size     = SIZE_4B;
      mem_addr     = '0;
      mem_wdata    = '0;
      unique case (state)
         IDLE: begin
            if (hs) state_next = sel_fault ? RESP : ISSUE;
         end
         ISSUE: begin
            // Strobes gated by rst so a reset landing here never commits a store.
            mem_en     = rst;
            mem_we     = rst & lat_we;
            mem_size   = lat_size;
            mem_addr   = lat_addr;
            mem_wdata  = lat_wdata;
            state_next = CAPTURE;
         end
         CAPTURE: begin
            state_next = RESP;
         end
         RESP: begin
            rsp_err = lat_err;
            if (lat_port_d) begin
               d_rsp_valid = 1'b1;
               d_rsp_data  = rsp_data;
            end else begin
               if_rsp_valid = 1'b1;
               if_rsp_data  = rsp_data[31:0];
            end
            if (rsp_taken) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!rst) begin
         lat_port_d <= 1'b0;
         lat_we     <= 1'b0;
         lat_size   <= 1'b0;
         lat_err    <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         rsp_data   <= '0;
      end else if (hs) begin
         lat_port_d <= grant_d;
         lat_we     <= grant_d & d_we;
         lat_size   <= sel_size;
         lat_err    <= sel_fault;
         lat_addr   <= sel_addr;
         lat_wdata  <= grant_d ? d_wdata : '0;
         rsp_data   <= '0;
      end else if (state == CAPTURE) begin
         if (lat_we)          rsp_data <= '0;
         else if (lat_port_d) rsp_data <= mem_rdata;
         else                 rsp_data <= {32'b0, mem_rdata[31:0]};
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

   localparam longint unsigned MB   = 64'h80000;
   localparam int              SMAX = 4;

   logic        clock = 1'b0;
   logic        rst = 1'b0;
   logic        if_req_valid = 1'b0, if_rsp_ready = 1'b0;
   logic [63:0] if_addr = '0;
   logic        d_req_valid = 1'b0, d_we = 1'b0, d_rsp_ready = 1'b0;
   logic [63:0] d_addr = '0, d_wdata = '0;
   logic        if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid, rsp_err;
   logic [31:0] if_rsp_data;
   logic [63:0] d_rsp_data;
   logic        mem_en, mem_we, mem_size;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;

   mem_port_arbiter #(.MEM_BYTES(MB), .STARVE_MAX(SMAX)) dut (
      .clock(clock), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
      .d_rsp_data(d_rsp_data), .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we),
      .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   // Memory device seen by the DUT, and an independent reference image.
   bit [7:0] dev_mem [0:int'(MB) + 7];
   bit [7:0] ref_mem [0:int'(MB) + 7];

   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int i = 0; i < (mem_size ? 8 : 4); i++)
               dev_mem[int'(mem_addr[19:0]) + i] <= mem_wdata[8*i +: 8];
         end else begin
            for (int i = 0; i < 8; i++)
               mem_rdata[8*i +: 8] <= dev_mem[int'(mem_addr[19:0]) + i];
         end
      end
   end

   function automatic logic [63:0] dev_rd(input logic [63:0] a);
      logic [63:0] v = '0;
      for (int i = 0; i < 8; i++) v[8*i +: 8] = dev_mem[int'(a[19:0]) + i];
      return v;
   endfunction

   function automatic logic [63:0] ref_rd(input logic [63:0] a);
      logic [63:0] v = '0;
      for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[int'(a[19:0]) + i];
      return v;
   endfunction

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct packed {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
   } dreq_t;

   logic [63:0] iq[$];
   dreq_t       dq[$];
   bit          order[$];

   // Model of the one outstanding transaction
   bit          busy = 0, acc_pend = 0, rel_pend = 0;
   int          age = 0, starve = 0, ready_mode = 0;
   bit          m_port_d = 0, m_we = 0, m_err = 0;
   logic [63:0] m_addr = '0, m_wdata = '0, m_data = '0;
   logic [63:0] last_data = '0;
   logic        last_err = 1'b0;
   bit          rst_issue = 0, rst_hit = 0;

   task automatic accept(input bit port_d, input logic [63:0] addr, input bit we,
                         input logic [63:0] wdata);
      logic [64:0] end_a;
      logic [63:0] rd;
      end_a    = {1'b0, addr} + (port_d ? 65'd8 : 65'd4);
      m_port_d = port_d;
      m_addr   = addr;
      m_we     = we;
      m_wdata  = wdata;
      m_err    = end_a > 65'(MB);
      rd       = m_err ? 64'd0 : ref_rd(addr);
      if (m_err || we) m_data = 64'd0;
      else if (port_d) m_data = rd;
      else             m_data = {32'b0, rd[31:0]};
      acc_pend = 1;
      order.push_back(port_d);
   endtask

   task automatic step();
      bit dec, exp_rv, exp_en, ivalid, dvalid, gi, gd;
      logic [63:0] got;
      @(negedge clock);
      if (acc_pend) begin
         busy = 1; age = 1; acc_pend = 0;
      end else if (busy) begin
         age++;
      end
      if (rel_pend) begin
         busy = 0; rel_pend = 0;
      end
      if (busy && age == 2 && m_we && !m_err)
         for (int i = 0; i < 8; i++) ref_mem[int'(m_addr[19:0]) + i] = m_wdata[8*i +: 8];

      ivalid       = iq.size() > 0;
      dvalid       = dq.size() > 0;
      if_req_valid = ivalid;
      if_addr      = ivalid ? iq[0] : '0;
      d_req_valid  = dvalid;
      d_we         = dvalid ? dq[0].we : 1'b0;
      d_addr       = dvalid ? dq[0].addr : '0;
      d_wdata      = dvalid ? dq[0].wdata : '0;

      if (rst_issue && busy && age == 1) begin
         rst = 1'b0;
         iq.delete();
         dq.delete();
         if_req_valid = 1'b0;
         d_req_valid  = 1'b0;
         #1;
         chk("rst_issue_mem_en", 64'(mem_en), 64'd0);
         chk("rst_issue_mem_we", 64'(mem_we), 64'd0);
         busy = 0; starve = 0; rst_issue = 0; rst_hit = 1;
         return;
      end

      exp_rv = busy && (age >= (m_err ? 1 : 3));
      case (ready_mode)
         0:       dec = 1'b1;
         1:       dec = 1'($urandom_range(0, 1));
         default: dec = 1'b0;
      endcase
      if_rsp_ready = dec;
      d_rsp_ready  = dec;
      #1;

      exp_en = busy && !m_err && age == 1;
      chk("mem_en", 64'(mem_en), 64'(exp_en));
      if (exp_en) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_we", 64'(mem_we), 64'(m_we));
         chk("mem_size", 64'(mem_size), 64'(m_port_d));
         if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end else begin
         chk("mem_we_idle", 64'(mem_we), 64'd0);
      end
      chk("if_rsp_valid", 64'(if_rsp_valid), 64'(exp_rv && !m_port_d));
      chk("d_rsp_valid", 64'(d_rsp_valid), 64'(exp_rv && m_port_d));
      chk("rsp_err", 64'(rsp_err), 64'(exp_rv && m_err));
      if (exp_rv) begin
         got = m_port_d ? d_rsp_data : {32'b0, if_rsp_data};
         chk("rsp_data", got, m_data);
         if (dec) begin
            rel_pend  = 1;
            last_data = got;
            last_err  = rsp_err;
         end
      end

      if (!busy) begin
         if (ivalid && dvalid) gi = (starve == SMAX);
         else                  gi = ivalid;
         gd = dvalid && !gi;
         chk("if_req_ready", 64'(if_req_ready), 64'(gi));
         chk("d_req_ready", 64'(d_req_ready), 64'(gd));
         if (gi || !ivalid)            starve = 0;
         else if (gd && starve < SMAX) starve++;
         if (gi) begin
            accept(1'b0, iq[0], 1'b0, 64'd0);
            void'(iq.pop_front());
         end else if (gd) begin
            accept(1'b1, dq[0].addr, dq[0].we, dq[0].wdata);
            void'(dq.pop_front());
         end
      end else begin
         chk("if_req_ready_busy", 64'(if_req_ready), 64'd0);
         chk("d_req_ready_busy", 64'(d_req_ready), 64'd0);
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((iq.size() > 0 || dq.size() > 0 || busy || acc_pend || rel_pend) && n < budget) begin
         step();
         n++;
      end
      chk("drain_in_budget", 64'(n < budget), 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ctrl"}, 64'({if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid,
                               rsp_err, mem_en, mem_we, mem_size}), 64'd0);
      chk({tag, "_if_data"}, 64'(if_rsp_data), 64'd0);
      chk({tag, "_d_data"}, d_rsp_data, 64'd0);
      chk({tag, "_mem_addr"}, mem_addr, 64'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
   endtask

   function automatic logic [63:0] rand_if_addr();
      int r = $urandom_range(0, 9);
      if (r < 8)  return 64'h1000 + 64'(4 * $urandom_range(0, 63));
      if (r == 8) return 64'h7FFFC;
      return 64'h7FFFD;
   endfunction

   function automatic dreq_t rand_d_req();
      dreq_t q;
      int r = $urandom_range(0, 9);
      q.we    = 1'($urandom_range(0, 1));
      q.wdata = {$urandom, $urandom};
      if (r < 7)       q.addr = 64'h1000 + 64'(8 * $urandom_range(0, 31));
      else if (r == 7) q.addr = 64'h7FFF8;
      else if (r == 8) q.addr = 64'h7FFF9 + 64'($urandom_range(0, 6));
      else             q.addr = 64'hFFFF_FFFF_FFFF_FFF8;
      return q;
   endfunction

   initial begin
      bit          exp_ord [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      logic [63:0] pre200;

      {dev_mem[32'h2003], dev_mem[32'h2002], dev_mem[32'h2001], dev_mem[32'h2000]} = 32'h12345678;
      {ref_mem[32'h2003], ref_mem[32'h2002], ref_mem[32'h2001], ref_mem[32'h2000]} = 32'h12345678;

      repeat (3) @(negedge clock);
      #1;
      check_all_zero("reset");
      rst = 1'b1;

      ready_mode = 0;
      iq.push_back(64'h2000);
      drain(20);
      chk("fetch_data", last_data, 64'h12345678);
      chk("fetch_err", 64'(last_err), 64'd0);

      dq.push_back('{1'b1, 64'h100, 64'hDEADBEEFCAFEF00D});
      dq.push_back('{1'b0, 64'h100, 64'd0});
      drain(30);
      chk("store_load_data", last_data, 64'hDEADBEEFCAFEF00D);

      dq.push_back('{1'b0, 64'h7FFF9, 64'd0});
      drain(20);
      chk("fault_load_data", last_data, 64'd0);
      chk("fault_load_err", 64'(last_err), 64'd1);

      iq.push_back(64'hFFFF_FFFF_FFFF_FFFE);
      drain(20);
      chk("wrap_fetch_err", 64'(last_err), 64'd1);

      ready_mode = 2;
      dq.push_back('{1'b0, 64'h100, 64'd0});
      repeat (4) step();
      iq.push_back(64'h2000);
      repeat (10) step();
      chk("hold_valid", 64'(d_rsp_valid), 64'd1);
      chk("hold_data", d_rsp_data, 64'hDEADBEEFCAFEF00D);
      chk("hold_not_accepted", 64'(iq.size()), 64'd1);
      ready_mode = 0;
      drain(30);

      order.delete();
      repeat (8) dq.push_back('{1'b0, 64'h100, 64'd0});
      repeat (2) iq.push_back(64'h2000);
      drain(100);
      chk("order_len", 64'(order.size()), 64'd10);
      for (int i = 0; i < 10 && i < order.size(); i++)
         chk($sformatf("order_%0d", i), 64'(order[i]), 64'(exp_ord[i]));

      ready_mode = 1;
      for (int c = 0; c < 400; c++) begin
         if (iq.size() == 0 && $urandom_range(0, 2) == 0) iq.push_back(rand_if_addr());
         if (dq.size() == 0 && $urandom_range(0, 2) == 0) dq.push_back(rand_d_req());
         step();
      end
      ready_mode = 0;
      drain(60);

      pre200    = dev_rd(64'h200);
      rst_hit   = 0;
      rst_issue = 1;
      dq.push_back('{1'b1, 64'h200, 64'h0123456789ABCDEF});
      for (int n = 0; n < 20 && !rst_hit; n++) step();
      chk("rst_issue_reached", 64'(rst_hit), 64'd1);
      rst_issue = 0;
      @(negedge clock);
      #1;
      check_all_zero("mid_reset");
      chk("mid_reset_mem", dev_rd(64'h200), pre200);
      rst = 1'b1;

      iq.push_back(64'h2000);
      drain(20);
      chk("post_reset_fetch", last_data, 64'h12345678);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
